// File: rtl/fixed_to_float.sv
// Multi-cycle converter: signed Q1.31 fixed point to IEEE-754 single precision.
// Optional build macro FIX2FLT_ROUND_EN selects round-to-nearest-even packing (default truncates).
module fixed_to_float (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: start is taken only when busy=0 and clk_en=1; done is a single
  // pulse (held while clk_en=0) and result stays valid until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    NORM = 2'd2,
    PACK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;

  logic [22:0] frac_pack;
  logic [7:0]  exp_pack;

`ifdef FIX2FLT_ROUND_EN
  logic        round_up;
  logic [23:0] frac_sum;

  // A carry out of the fraction leaves it zero and bumps the exponent.
  always_comb begin
    round_up  = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    frac_sum  = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    frac_pack = frac_sum[22:0];
    exp_pack  = exp_q + {7'd0, frac_sum[23]};
  end
`else
  logic unused_lsbs;

  always_comb begin
    frac_pack   = mag_q[30:8];
    exp_pack    = exp_q;
    unused_lsbs = ^mag_q[7:0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = dataa;
          state_d   = ABS;
        end
      end
      ABS: begin
        sign_d  = operand_q[31];
        mag_d   = operand_q[31] ? (~operand_q + 32'd1) : operand_q;
        exp_d   = 8'd127;
        state_d = (operand_q == 32'd0) ? PACK : NORM;
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = PACK;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      PACK: begin
        // Zero keeps exponent 127 in the register, so it is encoded explicitly.
        result_d = (mag_q == 32'd0) ? 32'd0 : {sign_q, exp_pack, frac_pack};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      operand_q <= 32'd0;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      operand_q <= operand_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Randomized and directed bench for fixed_to_float against an arithmetic reference model.
module tb_fixed_to_float;

  logic        clock;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fixed_to_float dut (
    .clock     (clock),
    .aclr      (aclr),
    .clk_en    (clk_en),
    .start     (start),
    .dataa     (dataa),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: value = a / 2^31, expressed as 1.f * 2^(p-31) with p the MSB index.
  function automatic longint unsigned ref_mag(input logic [31:0] a);
    return a[31] ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
  endfunction

  function automatic int ref_latency(input logic [31:0] a);
    longint unsigned m;
    int p;
    m = ref_mag(a);
    if (m == 0) return 2;
    p = $clog2(m + 1) - 1;
    return 3 + (31 - p);
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] a);
    longint unsigned m, norm, q, r;
    int p, e;
    m = ref_mag(a);
    if (m == 0) return 32'd0;
    p = $clog2(m + 1) - 1;
    e = 96 + p;
    norm = m << (31 - p);
    q = norm / 256;
    r = norm % 256;
`ifdef FIX2FLT_ROUND_EN
    if (r > 128 || (r == 128 && (q % 2) == 1)) q = q + 1;
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      e = e + 1;
    end
`endif
    return {a[31], e[7:0], q[22:0]};
  endfunction

  // Driver: issue one conversion with optional disturbances, timed by negedge index k.
  task automatic conv(input logic [31:0] a, input int extra_at, input int stall_at,
                      input int rst_at, input int hold_done);
    int k, lat_exp;
    bit seen, busy_ok;
    logic [31:0] exp_r;
    lat_exp = ref_latency(a) + ((stall_at > 0) ? 5 : 0);
    exp_q.push_back(ref_float(a));
    @(negedge clock);
    dataa = a;
    start = 1'b1;
    k = 0;
    seen = 0;
    busy_ok = 1;
    while (!seen && k < 80) begin
      @(negedge clock);
      k++;
      if (done) begin
        seen = 1;
      end else if (!busy) begin
        busy_ok = 0;
      end
      if (k == 1) begin
        start = 1'b0;
        dataa = $urandom;
      end
      if (extra_at > 0 && k == extra_at) begin
        start = 1'b1;
        dataa = 32'h4000_0000;
      end
      if (extra_at > 0 && k == extra_at + 1) start = 1'b0;
      if (stall_at > 0 && k == stall_at) clk_en = 1'b0;
      if (stall_at > 0 && k == stall_at + 5) clk_en = 1'b1;
      if (rst_at > 0 && k == rst_at) begin
        aclr = 1'b0;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        aclr = 1'b1;
        repeat (40) begin
          @(negedge clock);
          if (done) seen = 1;
        end
        check("rst_no_pulse", {31'd0, seen}, 32'd0);
        exp_r = exp_q.pop_front();
        return;
      end
    end
    check("timeout", {31'd0, seen}, 32'd1);
    if (!seen) begin
      exp_r = exp_q.pop_front();
      return;
    end
    exp_r = exp_q.pop_front();
    check("result", result, exp_r);
    check("latency", k - 1, lat_exp);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    if (hold_done > 0) begin
      clk_en = 1'b0;
      repeat (hold_done) @(negedge clock);
      check("done_frozen", {31'd0, done}, 32'd1);
      clk_en = 1'b1;
    end
    @(negedge clock);
    check("done_pulse", {31'd0, done}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check("no_extra_done", {31'd0, seen}, 32'd0);
    check("result_hold", result, exp_r);
  endtask

  initial begin
    logic [31:0] a;
    aclr = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    dataa = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    aclr = 1'b1;

    // directed vectors with literal expectations
    conv(32'h4000_0000, 0, 0, 0, 0);
    check("vec_half", result, 32'h3F00_0000);
    conv(32'h8000_0000, 0, 0, 0, 0);
    check("vec_neg_one", result, 32'hBF80_0000);
    conv(32'h0000_0000, 0, 0, 0, 0);
    check("vec_zero", result, 32'h0000_0000);
    conv(32'h4DBA_76D4, 0, 0, 0, 0);
`ifdef FIX2FLT_ROUND_EN
    check("vec_4dba", result, 32'h3F1B_74EE);
`else
    check("vec_4dba", result, 32'h3F1B_74ED);
`endif
    conv(32'h7FFF_FFFF, 0, 0, 0, 0);
`ifdef FIX2FLT_ROUND_EN
    check("vec_max", result, 32'h3F80_0000);
`else
    check("vec_max", result, 32'h3F7F_FFFF);
`endif
    conv(32'h0000_0001, 0, 0, 0, 0);
    check("vec_min", result, 32'h3000_0000);
    conv(32'hFFFF_FFFF, 0, 0, 0, 3);

    // ignored start during NORM, stall mid-NORM, reset mid-NORM, then recovery
    conv(32'h0000_0001, 5, 0, 0, 0);
    conv(32'h0000_0001, 0, 5, 0, 0);
    conv(32'h0000_0001, 0, 0, 5, 0);
    conv(32'h4000_0000, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      conv(a, 0, 0, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
